// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control unit.
// Contents: FSM state encoding (4-bit binary), opcode constants for the
// memory and halt instructions, and an ALU-opcode classifier.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_F_ADDR = 4'd1,
    S_F_RD   = 4'd2,
    S_F_IR   = 4'd3,
    S_DECODE = 4'd4,
    S_EX_ALU = 4'd5,
    S_M_ADDR = 4'd6,
    S_ST_WR  = 4'd7,
    S_LD_RD  = 4'd8,
    S_LD_WB  = 4'd9,
    S_PC_INC = 4'd10,
    S_HALT   = 4'd11
  } state_e;

  localparam logic [5:0] OP_LD   = 6'b000001;
  localparam logic [5:0] OP_ST   = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  // Any opcode with the MSB set is an ALU op, except the all-ones HALT.
  function automatic logic is_alu(input logic [5:0] op);
    return op[5] && (op != OP_HALT);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter used to hold the FSM in a RAM access state.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous active-high clear
//   load   - load `value` into the counter this edge
//   value  - reload value (number of wait cycles minus one)
//   done   - counter is zero; the owning state may exit this cycle
module mem_wait_timer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM sequencing the CPU datapath through fetch,
// decode, execute, memory and write-back. Outputs are a pure decode of the
// state register.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   start               - leave IDLE and begin fetching
//   opcode              - IR[31:26] fed back from the datapath
//   pcFetch ... wEn     - datapath enables/strobes
//   busy                - any state other than IDLE/HALT
//   halted              - in HALT
//   retired             - wrapping count of completed instructions
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  output logic             pcFetch,
  output logic             pcEn,
  output logic             irEn,
  output logic             marEn,
  output logic             ldEn,
  output logic             stEn,
  output logic             mdrEn,
  output logic             rd,
  output logic             wr,
  output logic             wEn,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // A wait of 0 is treated as a single access cycle.
  localparam int WAIT_EFF = (MEM_WAIT < 1) ? 1 : MEM_WAIT;
  localparam int WAIT_W   = (WAIT_EFF > 1) ? $clog2(WAIT_EFF) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_EFF - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             wait_load;
  logic             wait_done;

  // Reload the timer only on entry to a wait state so it counts down
  // while the state holds.
  assign wait_load = (state_d != state_q) &&
                     ((state_d == S_F_RD) || (state_d == S_ST_WR) ||
                      (state_d == S_LD_RD));

  mem_wait_timer #(
    .WIDTH (WAIT_W)
  ) u_wait (
    .clk   (clk),
    .reset (reset),
    .load  (wait_load),
    .value (WAIT_LOAD),
    .done  (wait_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_F_ADDR;
      S_F_ADDR: state_d = S_F_RD;
      S_F_RD:   if (wait_done) state_d = S_F_IR;
      S_F_IR:   state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_HALT)                         state_d = S_HALT;
        else if (is_alu(opcode))                       state_d = S_EX_ALU;
        else if ((opcode == OP_LD) || (opcode == OP_ST)) state_d = S_M_ADDR;
        else                                           state_d = S_PC_INC;
      end
      S_EX_ALU: state_d = S_PC_INC;
      // IR is held (irEn low) so the opcode seen here matches DECODE;
      // the PC_INC fallback only guards against a corrupted IR.
      S_M_ADDR: begin
        if (opcode == OP_ST)      state_d = S_ST_WR;
        else if (opcode == OP_LD) state_d = S_LD_RD;
        else                      state_d = S_PC_INC;
      end
      S_ST_WR:  if (wait_done) state_d = S_PC_INC;
      S_LD_RD:  if (wait_done) state_d = S_LD_WB;
      S_LD_WB:  state_d = S_PC_INC;
      S_PC_INC: begin
        state_d   = S_F_ADDR;
        retired_d = retired_q + CNT_W'(1);
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pcFetch = 1'b0;
    pcEn    = 1'b0;
    irEn    = 1'b0;
    marEn   = 1'b0;
    ldEn    = 1'b0;
    stEn    = 1'b0;
    mdrEn   = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    wEn     = 1'b0;
    case (state_q)
      S_F_ADDR: begin pcFetch = 1'b1; marEn = 1'b1; end
      S_F_RD:   begin pcFetch = 1'b1; rd = 1'b1; end
      S_F_IR:   begin pcFetch = 1'b1; rd = 1'b1; irEn = 1'b1; end
      S_EX_ALU: wEn = 1'b1;
      S_M_ADDR: marEn = 1'b1;
      S_ST_WR:  begin stEn = 1'b1; mdrEn = 1'b1; wr = 1'b1; end
      S_LD_RD:  begin ldEn = 1'b1; mdrEn = 1'b1; rd = 1'b1; end
      S_LD_WB:  begin ldEn = 1'b1; mdrEn = 1'b1; wEn = 1'b1; end
      S_PC_INC: pcEn = 1'b1;
      default:  ;
    endcase
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: a small behavioural datapath (PC, MAR, IR,
// register file, RAM) runs short programs under the main instance
// (MEM_WAIT=2, CNT_W=16); two extra instances (MEM_WAIT=0 and 1, CNT_W=4)
// are fed a directly driven opcode for the counter-wrap scenario.
module tb_cpu_control_unit;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_HALT = 32'hFC00_0000;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  opcode;
  logic        pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, rd, wr, wEn;
  logic        busy, halted;
  logic [15:0] retired;
  logic [9:0]  ctl;

  logic        start2;
  logic [5:0]  op2;
  logic [9:0]  c2, c3;
  logic        busy2, halted2, busy3, halted3;
  logic [3:0]  retired2, retired3;

  int vecs;
  int errs;

  assign ctl = {pcFetch, pcEn, irEn, marEn, ldEn, stEn, mdrEn, rd, wr, wEn};

  cpu_control_unit #(.MEM_WAIT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .pcFetch(pcFetch), .pcEn(pcEn), .irEn(irEn), .marEn(marEn),
    .ldEn(ldEn), .stEn(stEn), .mdrEn(mdrEn), .rd(rd), .wr(wr), .wEn(wEn),
    .busy(busy), .halted(halted), .retired(retired)
  );

  cpu_control_unit #(.MEM_WAIT(0), .CNT_W(4)) dut_w0 (
    .clk(clk), .reset(reset), .start(start2), .opcode(op2),
    .pcFetch(c2[9]), .pcEn(c2[8]), .irEn(c2[7]), .marEn(c2[6]),
    .ldEn(c2[5]), .stEn(c2[4]), .mdrEn(c2[3]), .rd(c2[2]), .wr(c2[1]),
    .wEn(c2[0]), .busy(busy2), .halted(halted2), .retired(retired2)
  );

  cpu_control_unit #(.MEM_WAIT(1), .CNT_W(4)) dut_w1 (
    .clk(clk), .reset(reset), .start(start2), .opcode(op2),
    .pcFetch(c3[9]), .pcEn(c3[8]), .irEn(c3[7]), .marEn(c3[6]),
    .ldEn(c3[5]), .stEn(c3[4]), .mdrEn(c3[3]), .rd(c3[2]), .wr(c3[1]),
    .wEn(c3[0]), .busy(busy3), .halted(halted3), .retired(retired3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural datapath; reset reloads the program and registers.
  logic [31:0] init_mem [0:31];
  logic [31:0] init_rf  [0:31];
  logic [31:0] mem      [0:31];
  logic [31:0] rf       [0:31];
  logic [4:0]  pc, mar;
  logic [31:0] ir;

  assign opcode = ir[31:26];

  always @(posedge clk) begin
    if (reset) begin
      pc  <= '0;
      mar <= '0;
      ir  <= '0;
      for (int i = 0; i < 32; i++) begin
        mem[i] <= init_mem[i];
        rf[i]  <= init_rf[i];
      end
    end else begin
      if (marEn) mar <= pcFetch ? pc : rf[ir[20:16]][4:0];
      if (irEn) ir <= mem[mar];
      if (wr && stEn) mem[mar] <= rf[ir[25:21]];
      if (wEn && ldEn) rf[ir[25:21]] <= mem[mar];
      else if (wEn) rf[ir[15:11]] <= (ir[31:26] == 6'b100001) ?
                                     rf[ir[25:21]] - rf[ir[20:16]] :
                                     rf[ir[25:21]] + rf[ir[20:16]];
      if (pcEn) pc <= pc + 5'd1;
    end
  end

  int fa_q[$];
  int wen_cnt, wen_first, pcen_cnt, ovl, halt_cyc;

  task automatic clear_init();
    for (int i = 0; i < 32; i++) begin
      init_mem[i] = '0;
      init_rf[i]  = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Pulse start, then observe each cycle until HALT (bounded).
  // spur >= 0 re-pulses start at that cycle.
  task automatic run_main(input int spur);
    fa_q.delete();
    wen_cnt = 0; wen_first = -1; pcen_cnt = 0; ovl = 0; halt_cyc = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (pcFetch && marEn) fa_q.push_back(c);
      if (wEn) begin
        wen_cnt++;
        if (wen_first < 0) wen_first = c;
      end
      if (pcEn) pcen_cnt++;
      if (rd && wr) ovl++;
      if (halted) begin
        halt_cyc = c;
        break;
      end
      start = (c == spur);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  function automatic int fa_at(input int k);
    return (fa_q.size() > k) ? fa_q[k] : -1;
  endfunction

  task automatic test_reset();
    start = 1'b0; start2 = 1'b0; op2 = 6'd0;
    clear_init();
    do_reset();
    vecs++; if (ctl !== 10'd0) begin errs++; $display("FAIL reset_ctl: got %b expected 0", ctl); end
    vecs++; if ({busy, halted} !== 2'b00) begin errs++; $display("FAIL reset_busy_halted: got %b expected 00", {busy, halted}); end
    vecs++; if (retired !== 16'd0) begin errs++; $display("FAIL reset_retired: got %0d expected 0", retired); end
    vecs++; if ({c2, c3, busy2, busy3, halted2, halted3, retired2, retired3} !== 32'd0) begin
      errs++; $display("FAIL reset_aux: got %h expected 0", {c2, c3, busy2, busy3, halted2, halted3, retired2, retired3});
    end
    repeat (3) @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_no_start: busy %b expected 0", busy); end
  endtask

  task automatic test_nop_halt();
    clear_init();
    init_mem[0] = I_NOP;
    init_mem[1] = I_HALT;
    do_reset();
    run_main(-1);
    vecs++; if (fa_at(1) - fa_at(0) !== 6) begin errs++; $display("FAIL nop_cpi: got %0d expected 6", fa_at(1) - fa_at(0)); end
    vecs++; if (halt_cyc !== 11) begin errs++; $display("FAIL nop_halt_cycle: got %0d expected 11", halt_cyc); end
    vecs++; if (retired !== 16'd1) begin errs++; $display("FAIL nop_retired: got %0d expected 1", retired); end
    vecs++; if (pcen_cnt !== 1) begin errs++; $display("FAIL nop_pcen_pulses: got %0d expected 1", pcen_cnt); end
    vecs++; if ({busy, halted} !== 2'b01) begin errs++; $display("FAIL nop_halted_flags: got %b expected 01", {busy, halted}); end
  endtask

  task automatic test_alu();
    clear_init();
    init_mem[0] = {6'b100000, 5'd6, 5'd7, 5'd8, 11'd0};
    init_mem[1] = {6'b100001, 5'd7, 5'd6, 5'd9, 11'd0};
    init_mem[2] = I_HALT;
    init_rf[6] = 32'd6;
    init_rf[7] = 32'd7;
    do_reset();
    run_main(-1);
    vecs++; if (rf[8] !== 32'd13) begin errs++; $display("FAIL alu_add: got %0d expected 13", rf[8]); end
    vecs++; if (rf[9] !== 32'd1) begin errs++; $display("FAIL alu_sub: got %0d expected 1", rf[9]); end
    vecs++; if (fa_at(1) - fa_at(0) !== 7) begin errs++; $display("FAIL alu_cpi: got %0d expected 7", fa_at(1) - fa_at(0)); end
    vecs++; if (wen_cnt !== 2) begin errs++; $display("FAIL alu_wen_cycles: got %0d expected 2", wen_cnt); end
    vecs++; if (wen_first !== 5) begin errs++; $display("FAIL alu_wen_at: got %0d expected 5", wen_first); end
    vecs++; if (halt_cyc !== 19) begin errs++; $display("FAIL alu_halt_cycle: got %0d expected 19", halt_cyc); end
    vecs++; if (retired !== 16'd2) begin errs++; $display("FAIL alu_retired: got %0d expected 2", retired); end
  endtask

  task automatic test_ld_st();
    clear_init();
    init_mem[0] = {6'b000010, 5'd1, 5'd0, 16'd0};
    init_mem[1] = {6'b000001, 5'd31, 5'd0, 16'd0};
    init_mem[2] = I_HALT;
    init_rf[1] = 32'd1;
    do_reset();
    run_main(-1);
    vecs++; if (mem[0] !== 32'd1) begin errs++; $display("FAIL st_ram0: got %0d expected 1", mem[0]); end
    vecs++; if (rf[31] !== 32'd1) begin errs++; $display("FAIL ld_r31: got %0d expected 1", rf[31]); end
    vecs++; if (fa_at(1) - fa_at(0) !== 9) begin errs++; $display("FAIL st_cpi: got %0d expected 9", fa_at(1) - fa_at(0)); end
    vecs++; if (fa_at(2) - fa_at(1) !== 10) begin errs++; $display("FAIL ld_cpi: got %0d expected 10", fa_at(2) - fa_at(1)); end
    vecs++; if (ovl !== 0) begin errs++; $display("FAIL rd_wr_overlap: got %0d cycles expected 0", ovl); end
    vecs++; if (wen_cnt !== 1) begin errs++; $display("FAIL ldst_wen_cycles: got %0d expected 1", wen_cnt); end
    vecs++; if (pcen_cnt !== 2) begin errs++; $display("FAIL ldst_pcen: got %0d expected 2", pcen_cnt); end
    vecs++; if (halt_cyc !== 24) begin errs++; $display("FAIL ldst_halt_cycle: got %0d expected 24", halt_cyc); end
  endtask

  task automatic test_reset_mid_ld();
    clear_init();
    init_mem[0] = I_NOP;
    init_mem[1] = {6'b000001, 5'd2, 5'd3, 16'd0};
    init_mem[2] = I_HALT;
    init_mem[5] = 32'd42;
    init_rf[3]  = 32'd5;
    do_reset();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    // cycle 13: second LD_RD cycle
    vecs++; if ({ldEn, mdrEn, rd, retired} !== {3'b111, 16'd1}) begin
      errs++; $display("FAIL mid_ld_state: got %b/%0d expected 111/1", {ldEn, mdrEn, rd}, retired);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vecs++; if ({ctl, busy, halted} !== 12'd0) begin errs++; $display("FAIL mid_ld_outputs: got %b expected 0", {ctl, busy, halted}); end
    vecs++; if (retired !== 16'd0) begin errs++; $display("FAIL mid_ld_retired: got %0d expected 0", retired); end
    @(negedge clk);
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_ld_idle: busy %b expected 0", busy); end
    run_main(-1);
    vecs++; if (fa_at(1) !== 6 || fa_at(2) !== 16) begin
      errs++; $display("FAIL refetch_timing: got %0d,%0d expected 6,16", fa_at(1), fa_at(2));
    end
    vecs++; if (rf[2] !== 32'd42) begin errs++; $display("FAIL refetch_ld: got %0d expected 42", rf[2]); end
    vecs++; if (retired !== 16'd2) begin errs++; $display("FAIL refetch_retired: got %0d expected 2", retired); end
  endtask

  task automatic test_start_ignored();
    clear_init();
    init_mem[0] = I_NOP;
    init_mem[1] = I_HALT;
    do_reset();
    run_main(1);
    vecs++; if (fa_q.size() !== 2 || fa_at(1) !== 6) begin
      errs++; $display("FAIL spur_frd_seq: got %0d entries, second at %0d expected 2 at 6", fa_q.size(), fa_at(1));
    end
    vecs++; if (halt_cyc !== 11) begin errs++; $display("FAIL spur_frd_halt: got %0d expected 11", halt_cyc); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vecs++; if ({halted, busy, ctl} !== {2'b10, 10'd0}) begin
        errs++; $display("FAIL spur_halt_%0d: got %b expected 10_0000000000", k, {halted, busy, ctl});
      end
      @(negedge clk);
    end
    vecs++; if (retired !== 16'd1) begin errs++; $display("FAIL spur_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_wrap();
    int fa2[$], fa3[$];
    int p2, p3, h2, h3;
    p2 = 0; p3 = 0; h2 = -1; h3 = -1;
    op2 = 6'd0;
    do_reset();
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c2[9] && c2[6]) fa2.push_back(c);
      if (c3[9] && c3[6]) fa3.push_back(c);
      if (c2[8]) p2++;
      if (c3[8]) p3++;
      if (halted2 && h2 < 0) h2 = c;
      if (halted3 && h3 < 0) h3 = c;
      if (h2 >= 0 && h3 >= 0) break;
      if (p2 == 17) op2 = 6'b111111;
      @(negedge clk);
    end
    vecs++; if (fa2.size() < 2 || fa2[1] - fa2[0] !== 5) begin errs++; $display("FAIL w0_cpi: got %0d entries expected cpi 5", fa2.size()); end
    vecs++; if (fa3.size() < 2 || fa3[1] - fa3[0] !== 5) begin errs++; $display("FAIL w1_cpi: got %0d entries expected cpi 5", fa3.size()); end
    vecs++; if (retired2 !== 4'd1) begin errs++; $display("FAIL w0_wrap: got %0d expected 1", retired2); end
    vecs++; if (retired3 !== 4'd1) begin errs++; $display("FAIL w1_wrap: got %0d expected 1", retired3); end
    vecs++; if (h2 !== 89) begin errs++; $display("FAIL w0_halt_cycle: got %0d expected 89", h2); end
    vecs++; if (h3 !== 89) begin errs++; $display("FAIL w1_halt_cycle: got %0d expected 89", h3); end
    vecs++; if (p2 !== 17 || p3 !== 17) begin errs++; $display("FAIL wrap_pcen: got %0d/%0d expected 17/17", p2, p3); end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    op2 = 6'd0;
    clear_init();
    @(negedge clk);
    test_reset();
    test_nop_halt();
    test_alu();
    test_ld_st();
    test_reset_mid_ld();
    test_start_ignored();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
